// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional oversample tick and bit tick generator.
// Divisor updates are shadowed and applied only on a tick boundary.
module baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int RST_DIV  = 27,
  parameter int RST_FRAC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              load,
  output logic              tick,
  output logic              bit_tick,
  output logic              pending
);

  localparam int OS_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);

  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic              tick_q, tick_d;
  logic              bit_q, bit_d;

  logic [DIV_W:0]    term;
  logic [FRAC_W:0]   frac_sum;
  logic              wrap;
  logic              apply;
  logic              os_last;

  // Terminal count widened by one bit so all-ones divisor plus extra fits.
  always_comb begin
    term     = {1'b0, act_int_q} + {{DIV_W{1'b0}}, extra_q};
    frac_sum = {1'b0, acc_q} + {1'b0, act_frac_q};
    wrap     = en && (cnt_q >= term);
    apply    = (wrap || !en) && (pend_q || load);
    os_last  = (os_q == OS_LAST);
  end

  // Next state: period counter, phase accumulator, oversample count, loads.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    extra_d    = extra_q;
    os_d       = os_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    bit_d      = 1'b0;
    if (!en) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      os_d    = '0;
    end else if (wrap) begin
      cnt_d            = '0;
      tick_d           = 1'b1;
      {extra_d, acc_d} = frac_sum;
      bit_d            = os_last;
      os_d             = os_last ? '0 : os_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (load) begin
      sh_int_d  = div_int;
      sh_frac_d = div_frac;
      pend_d    = 1'b1;
    end
    // Same-cycle load bypasses the shadow; os_d left alone to keep framing.
    if (apply) begin
      act_int_d  = load ? div_int  : sh_int_q;
      act_frac_d = load ? div_frac : sh_frac_q;
      acc_d      = '0;
      extra_d    = 1'b0;
      pend_d     = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      extra_q    <= 1'b0;
      os_q       <= '0;
      act_int_q  <= DIV_W'(RST_DIV);
      act_frac_q <= FRAC_W'(RST_FRAC);
      sh_int_q   <= '0;
      sh_frac_q  <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      extra_q    <= extra_d;
      os_q       <= os_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
    end
  end

  assign tick     = tick_q;
  assign bit_tick = bit_q;
  assign pending  = pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: table vectors, corner sequences and random
// stimulus against a closed-form tick-time reference model.
module tb_baud_gen_frac;

  localparam int DIV_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OSR      = 4;
  localparam int RST_DIV  = 3;
  localparam int RST_FRAC = 0;

  logic              clk = 1'b0;
  logic              rst_r = 1'b1;
  logic              en_r = 1'b0;
  logic              ld_r = 1'b0;
  logic [DIV_W-1:0]  di_r = '0;
  logic [FRAC_W-1:0] df_r = '0;
  logic              tick;
  logic              bit_tick;
  logic              pending;

  int n_cmp = 0;
  int n_bad = 0;

  baud_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR),
    .RST_DIV(RST_DIV), .RST_FRAC(RST_FRAC)
  ) dut (
    .clk(clk), .reset(rst_r), .en(en_r),
    .div_int(di_r), .div_frac(df_r), .load(ld_r),
    .tick(tick), .bit_tick(bit_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: tick n after a restart lands at edge
  // ref + n*(a+1) + floor((n-1)*f / 2^FRAC_W).
  longint m_e = 0;
  longint m_ref = 0;
  longint m_n = 1;
  longint m_ai = RST_DIV;
  longint m_af = RST_FRAC;
  longint m_si = 0;
  longint m_sf = 0;
  int     m_os = 0;
  bit     m_pend = 0;
  bit     m_tick = 0;
  bit     m_bit = 0;

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               nm, got, exp, m_e);
    end
  endtask

  task automatic model_step(input bit r, input bit e,
                            input bit ld, input longint di,
                            input longint df);
    bit ap;
    longint tgt;
    m_e++;
    if (r) begin
      m_ai = RST_DIV; m_af = RST_FRAC;
      m_si = 0; m_sf = 0; m_pend = 0;
      m_os = 0; m_tick = 0; m_bit = 0;
      m_ref = m_e; m_n = 1;
      return;
    end
    ap = 0;
    if (!e) begin
      m_tick = 0; m_bit = 0; m_os = 0;
      m_ref = m_e; m_n = 1;
      ap = m_pend || ld;
    end else begin
      tgt = m_ref + m_n * (m_ai + 1)
          + (((m_n - 1) * m_af) >> FRAC_W);
      if (m_e == tgt) begin
        m_tick = 1;
        m_bit = (m_os == OSR - 1);
        m_os = (m_os + 1) % OSR;
        ap = m_pend || ld;
        if (ap) begin
          m_ref = m_e; m_n = 1;
        end else begin
          m_n++;
        end
      end else begin
        m_tick = 0; m_bit = 0;
      end
    end
    if (ap) begin
      if (ld) begin
        m_ai = di; m_af = df;
      end else begin
        m_ai = m_si; m_af = m_sf;
      end
      m_pend = 0;
    end
    if (ld) begin
      m_si = di; m_sf = df;
      if (!ap) m_pend = 1;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit ld,
                     input int di, input int df);
    rst_r = r;
    en_r = e;
    ld_r = ld;
    di_r = DIV_W'(di);
    df_r = FRAC_W'(df);
    model_step(r, e, ld, di, df);
    @(posedge clk);
    #1;
    chk("tick", tick, m_tick);
    chk("bit_tick", bit_tick, m_bit);
    chk("pending", pending, m_pend);
  endtask

  task automatic wait_tick(input int bound, output int n);
    bit got;
    got = 0;
    n = 0;
    for (int i = 0; i < bound; i++) begin
      cyc(0, 1, 0, 0, 0);
      n++;
      if (tick) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      $display("FAIL wait_tick: no tick within %0d cycles", bound);
      n = -1;
    end
  endtask

  typedef struct {
    bit     en;
    bit     ld;
    int     di;
    int     df;
    int     cycles;
    int     exp_ticks;
    int     exp_bits;
    bit     exp_pend;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int nt, nb, gap;
    tbl[0] = '{0, 0, 0, 0,   2,   0,  0, 0};
    tbl[1] = '{1, 0, 0, 0,  16,   4,  1, 0};
    tbl[2] = '{1, 0, 0, 0,  16,   4,  1, 0};
    tbl[3] = '{0, 1, 3, 8,   1,   0,  0, 0};
    tbl[4] = '{1, 0, 0, 0, 720, 160, 40, 0};
    tbl[5] = '{0, 1, 0, 0,   1,   0,  0, 0};
    tbl[6] = '{1, 0, 0, 0,   8,   8,  2, 0};
    tbl[7] = '{0, 1, 9, 0,   1,   0,  0, 0};
    tbl[8] = '{1, 0, 0, 0,  25,   2,  0, 0};

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 5, 5);
    chk("rst_tick", tick, 0);
    chk("rst_pend", pending, 0);

    for (int v = 0; v < 9; v++) begin
      nt = 0;
      nb = 0;
      for (int c = 0; c < tbl[v].cycles; c++) begin
        cyc(0, tbl[v].en, tbl[v].ld && (c == 0),
            tbl[v].di, tbl[v].df);
        nt += int'(tick);
        nb += int'(bit_tick);
      end
      chk($sformatf("tbl%0d_ticks", v), nt, tbl[v].exp_ticks);
      chk($sformatf("tbl%0d_bits", v), nb, tbl[v].exp_bits);
      chk($sformatf("tbl%0d_pend", v), pending, tbl[v].exp_pend);
    end

    // Mid-period load at rate 9, five cycles into the period.
    cyc(0, 1, 1, 2, 0);
    chk("mid_pend_set", pending, 1);
    wait_tick(20, gap);
    chk("mid_old_gap", gap, 4);
    chk("mid_pend_clr", pending, 0);
    chk("mid_bit0", bit_tick, 0);
    wait_tick(20, gap);
    chk("mid_new_gap", gap, 3);
    chk("mid_bit1", bit_tick, 1);

    // Load landing on the exact wrap edge.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 5, 0);
    chk("wrap_ld_tick", tick, 1);
    chk("wrap_ld_pend", pending, 0);
    wait_tick(20, gap);
    chk("wrap_ld_gap", gap, 6);

    // Back-to-back loads: last one wins.
    cyc(0, 1, 1, 7, 0);
    chk("b2b_pend1", pending, 1);
    cyc(0, 1, 1, 5, 0);
    chk("b2b_pend2", pending, 1);
    wait_tick(20, gap);
    chk("b2b_old_gap", gap, 4);
    chk("b2b_pend_clr", pending, 0);
    wait_tick(20, gap);
    chk("b2b_new_gap", gap, 6);

    // Asynchronous reset with a load pending.
    cyc(0, 1, 1, 9, 0);
    cyc(0, 1, 0, 0, 0);
    chk("ar_pend_before", pending, 1);
    rst_r = 1'b1;
    #2;
    chk("ar_pend_async", pending, 0);
    chk("ar_tick_async", tick, 0);
    chk("ar_bit_async", bit_tick, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 8, 0);
    cyc(0, 0, 0, 0, 0);
    wait_tick(20, gap);
    chk("ar_first_gap", gap, RST_DIV + 1);
    wait_tick(20, gap);
    chk("ar_second_gap", gap, RST_DIV + 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc(0, $urandom_range(0, 19) != 0,
          $urandom_range(0, 24) == 0,
          int'($urandom_range(0, 6)),
          int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised fractional baud-rate generator; successor to the integer-only oversampling tick generator.
- Produces a 1-cycle oversample tick with a fractional average period, and a 1-cycle bit tick every OSR oversample ticks.
- Divisor changes are glitch-free: new values take effect only on a tick boundary.
- Feeds the UART TX/RX samplers; also usable as a generic SPI/I2C bit-rate strobe.

Parameters:
- DIV_W, 16: width of the integer divisor and the period counter.
- FRAC_W, 4: width of the fractional divisor and the phase accumulator.
- OSR, 16: oversample ticks per bit_tick; legal range 2..256.
- RST_DIV, 27: integer divisor loaded at reset.
- RST_FRAC, 2: fractional divisor loaded at reset.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- en, in, 1: run enable.
- div_int, in, DIV_W: requested integer divisor.
- div_frac, in, FRAC_W: requested fractional divisor, in units of 1/2^FRAC_W.
- load, in, 1: 1-cycle request to adopt div_int/div_frac.
- tick, out, 1: oversample strobe, 1-cycle pulse, registered.
- bit_tick, out, 1: bit strobe, 1-cycle pulse, registered, coincident with a tick.
- pending, out, 1: a loaded divisor is waiting to be applied.

Behaviour:
- One clock domain; reset is asynchronous and active-high, ports named clk and reset.
- Reset values: tick=0, bit_tick=0, pending=0; cnt=0, acc=0, extra=0, os_cnt=0; active divisor = RST_DIV/RST_FRAC; shadow registers = 0.
- Reset asserted mid-operation clears everything immediately, including any pending load.
- State: cnt (DIV_W+1 bits), acc (FRAC_W bits), extra (1 bit), os_cnt (clog2(OSR) bits), active divisor, shadow divisor, pending.
- Terminal count: term = act_int + extra, computed in DIV_W+1 bits so there is no overflow at act_int = all-ones.
- en=1, cnt < term: cnt <= cnt+1; tick <= 0; bit_tick <= 0.
- en=1, cnt >= term (wrap):
  - cnt <= 0; tick <= 1 in the next cycle.
  - {extra, acc} <= acc + act_frac (FRAC_W+1-bit sum; the carry sets extra for the following period).
  - bit_tick <= (os_cnt == OSR-1).
  - os_cnt <= (os_cnt == OSR-1) ? 0 : os_cnt+1.
- Resulting timing:
  - Tick spacing is act_int+1 cycles, or act_int+2 when extra=1.
  - Long-run average spacing is act_int + 1 + act_frac/2^FRAC_W.
  - Latency: with en rising and cnt=0, the first tick is high act_int+1 cycles after the first enabled edge.
- en=0:
  - cnt, acc, extra and os_cnt are synchronously cleared; tick=bit_tick=0.
  - If pending=1, it is applied on that cycle.
  - On re-enable, the tick and bit sequence restarts from phase 0.
- Load handling:
  - load=1: shadow <= {div_int, div_frac}; pending <= 1.
  - A later load before application overwrites the shadow (last write wins).
- Apply: occurs on a wrap, or on any cycle with en=0, when pending=1 or load=1.
  - active <= load ? inputs : shadow (the same-cycle load bypasses the shadow).
  - acc <= 0; extra <= 0; pending <= 0.
  - os_cnt is not disturbed, so bit framing is preserved across rate changes.
- Boundary cases:
  - act_int=0, act_frac=0: tick high every cycle once running (the counter condition is true every cycle).
  - act_frac=0: strictly periodic ticks, equivalent to the integer generator.
  - load coincident with reset: reset wins.
- No combinational path from any input to any output.

Test Plan:
- RST_DIV=3, RST_FRAC=0, OSR=4, en=1 after reset -> first tick on cycle 4; ticks every 4 cycles; bit_tick on every 4th tick (every 16 cycles); pending=0 throughout.
- div_int=3, div_frac=8, FRAC_W=4 via load with en=0 -> pending clears next cycle; after enable, tick gaps repeat 4,4,5,4,5,4,5…; 160 ticks span exactly 720 cycles (average 4.5).
- div_int=0, div_frac=0 -> tick continuously high after the first enabled cycle; bit_tick high every OSR-th cycle.
- While running at div_int=9, pulse load with div_int=2 mid-period -> pending=1; the current 10-cycle period completes; the next gaps are 3 cycles; pending drops on the wrap; the os_cnt phase is continuous (bit_tick spacing = 2 old-rate + … new-rate ticks as computed).
- load pulsed on the exact wrap cycle with div_int=5 -> new value is used from the next period; two back-to-back loads (7 then 5) -> 5 is applied.
- Assert reset mid-period with pending=1 -> tick, bit_tick and pending go 0 asynchronously; after release, the period reverts to RST_DIV/RST_FRAC and the first tick arrives RST_DIV+1 cycles after enable.
